// File: rtl/mdiv_pkg.sv
// Shared definitions for the mdiv divide controller: state encoding,
// default iteration geometry and the E-stage stall window.
package mdiv_pkg;

  localparam int DIV_ITERS_DFLT = 16;
  localparam int CNT_W_DFLT     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CYC0  = 3'd1,
    ST_FIRST = 3'd2,
    ST_ITER  = 3'd3,
    ST_LAST  = 3'd4
  } div_state_e;

  // One bit per state encoding: HI/LO readers must stall in CYC0, FIRST and ITER
  localparam logic [7:0] STALL_MASK = 8'b0000_1110;

  function automatic logic in_stall_window(input div_state_e s);
    return STALL_MASK[s];
  endfunction

endpackage

// File: rtl/mdiv_ctl.sv
// Sequencing FSM for the radix-4 divide datapath mdiv.
// Define MDIV_DIVZERO_FLAG_EN to build the divisor-was-zero flag.
module mdiv_ctl
  import mdiv_pkg::*;
#(
  parameter int DIV_ITERS = DIV_ITERS_DFLT,
  parameter int CNT_W     = CNT_W_DFLT
) (
  input  logic        CLK,
  input  logic        RESET_D2_R_N,
  input  logic        DivStart_E,
  input  logic        DivUns_E,
  input  logic [31:0] CEI_BOPandV_E,
  input  logic        DivKill,
  input  logic        MfHiLo_E,
  output logic        DIVxInProg,
  output logic        DivDCyc0_R,
  output logic        DivDCyc0Go,
  output logic        DivDCycFirst_R,
  output logic        DivDCycZF_R_N,
  output logic        DivDCycFL_R_N,
  output logic        DivDCycLast_P,
  output logic        DivDCycLast_R,
  output logic        DivIsU_R,
  output logic        HiWrEn,
  output logic        LoWrEn,
  output logic        DivStall,
  output logic        DivZero_R
);

  div_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             isu_r;
  logic             start_ok_s;

  // Next-state and iteration-counter logic; a kill overrides every active state
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    start_ok_s  = 1'b0;
    if (DivKill && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (DivStart_E && !DivKill) begin
            start_ok_s  = 1'b1;
            state_nxt_s = ST_CYC0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CYC0:  state_nxt_s = ST_FIRST;
        ST_FIRST: begin
          state_nxt_s = ST_ITER;
          cnt_nxt_s   = CNT_W'(DIV_ITERS - 1);
        end
        ST_ITER: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nxt_s = ST_LAST;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
        ST_LAST:  state_nxt_s = ST_IDLE;
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counter and unsigned-flag registers
  always_ff @(posedge CLK or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      isu_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (start_ok_s) begin
        isu_r <= DivUns_E;
      end else begin
        isu_r <= isu_r;
      end
    end
  end

  assign DIVxInProg     = (state_r != ST_IDLE);
  assign DivDCyc0_R     = (state_r == ST_CYC0);
  assign DivDCyc0Go     = DivDCyc0_R & ~DivKill;
  assign DivDCycFirst_R = (state_r == ST_FIRST);
  assign DivDCycZF_R_N  = ~(DivDCyc0_R | DivDCycFirst_R);
  assign DivDCycFL_R_N  = (state_r == ST_ITER);
  assign DivDCycLast_P  = (state_r == ST_ITER) & (cnt_r == {CNT_W{1'b0}});
  assign DivDCycLast_R  = (state_r == ST_LAST);
  assign DivIsU_R       = isu_r;
  assign HiWrEn         = DivDCycLast_R & ~DivKill;
  assign LoWrEn         = DivDCycLast_R & ~DivKill;
  // In LAST the result is bypassed from the datapath, so readers need not wait
  assign DivStall       = in_stall_window(state_r) & (MfHiLo_E | DivStart_E);

`ifdef MDIV_DIVZERO_FLAG_EN
  logic zero_r;

  // Divisor-zero flag captured on each accepted start
  always_ff @(posedge CLK or negedge RESET_D2_R_N) begin
    if (!RESET_D2_R_N) begin
      zero_r <= 1'b0;
    end else if (start_ok_s) begin
      zero_r <= (CEI_BOPandV_E == 32'd0);
    end else begin
      zero_r <= zero_r;
    end
  end

  assign DivZero_R = zero_r;
`else
  logic unused_divisor_s;
  assign unused_divisor_s = ^CEI_BOPandV_E;
  assign DivZero_R        = 1'b0;
`endif

endmodule

// File: tb/tb_mdiv_ctl.sv
// Self-checking bench for mdiv_ctl: table of divide scenarios checked cycle by
// cycle against an offset-based model, with a write-enable scoreboard.
module tb_mdiv_ctl;

  logic        CLK = 1'b0;
  logic        RESET_D2_R_N;
  logic        DivStart_E, DivUns_E, DivKill, MfHiLo_E;
  logic [31:0] CEI_BOPandV_E;
  logic        DIVxInProg, DivDCyc0_R, DivDCyc0Go, DivDCycFirst_R, DivDCycZF_R_N;
  logic        DivDCycFL_R_N, DivDCycLast_P, DivDCycLast_R, DivIsU_R;
  logic        HiWrEn, LoWrEn, DivStall, DivZero_R;

`ifdef MDIV_DIVZERO_FLAG_EN
  localparam bit ZF_EN = 1'b1;
`else
  localparam bit ZF_EN = 1'b0;
`endif

  mdiv_ctl dut (
    .CLK(CLK), .RESET_D2_R_N(RESET_D2_R_N), .DivStart_E(DivStart_E),
    .DivUns_E(DivUns_E), .CEI_BOPandV_E(CEI_BOPandV_E), .DivKill(DivKill),
    .MfHiLo_E(MfHiLo_E), .DIVxInProg(DIVxInProg), .DivDCyc0_R(DivDCyc0_R),
    .DivDCyc0Go(DivDCyc0Go), .DivDCycFirst_R(DivDCycFirst_R),
    .DivDCycZF_R_N(DivDCycZF_R_N), .DivDCycFL_R_N(DivDCycFL_R_N),
    .DivDCycLast_P(DivDCycLast_P), .DivDCycLast_R(DivDCycLast_R),
    .DivIsU_R(DivIsU_R), .HiWrEn(HiWrEn), .LoWrEn(LoWrEn),
    .DivStall(DivStall), .DivZero_R(DivZero_R)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        uns;
    logic [31:0] divisor;
    int          kill_at;     // cycle offset of DivKill, 0 = none
    int          rst_at;      // cycle offset of async reset, 0 = none
    logic [31:0] mf_mask;     // MfHiLo_E per cycle offset
    logic [31:0] start_mask;  // extra DivStart_E per cycle offset (k>0)
  } vec_t;

  typedef struct {
    logic exp_wr;
    int   exp_at;
  } sb_t;

  vec_t tbl[7];
  sb_t  sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic m_isu  = 1'b0;
  logic m_zero = 1'b0;

  logic [12:0] got_s;
  assign got_s = {DIVxInProg, DivDCyc0_R, DivDCyc0Go, DivDCycFirst_R, DivDCycZF_R_N,
                  DivDCycFL_R_N, DivDCycLast_P, DivDCycLast_R, HiWrEn, LoWrEn,
                  DivStall, DivIsU_R, DivZero_R};

  // Expected outputs k cycles after the start was sampled (k>=20 means idle).
  function automatic logic [12:0] model_out(input int k, input int kill_at,
      input logic kill_now, input logic mf, input logic st_in,
      input logic isu, input logic zero);
    int   st;
    logic inprog, c0, fst, it, lst;
    if (k == 0) st = 0;
    else if (kill_at != 0 && k > kill_at) st = 0;
    else if (k == 1) st = 1;
    else if (k == 2) st = 2;
    else if (k <= 18) st = 3;
    else if (k == 19) st = 4;
    else st = 0;
    inprog = (st != 0);
    c0 = (st == 1); fst = (st == 2); it = (st == 3); lst = (st == 4);
    return {inprog, c0, c0 & ~kill_now, fst, ~(c0 | fst), it, it & (k == 18), lst,
            lst & ~kill_now, lst & ~kill_now, inprog & ~lst & (mf | st_in), isu, zero};
  endfunction

  task automatic check(input string nm, input int k, input logic [12:0] got,
                       input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%b exp=%b (inprog,c0,go,first,zf_n,fl_n,last_p,last_r,hi,lo,stall,isu,zero)",
               nm, k, got, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic kill_now;
    sb_t  e;
    for (int k = 0; k < 24; k++) begin
      kill_now      = (v.kill_at != 0) && (k == v.kill_at);
      DivStart_E    = (k == 0) ? 1'b1 : v.start_mask[k];
      DivUns_E      = (k == 0) ? v.uns : 1'($urandom_range(1, 0));
      CEI_BOPandV_E = (k == 0) ? v.divisor : $urandom();
      DivKill       = kill_now;
      MfHiLo_E      = v.mf_mask[k];
      if (k == 0) sb_q.push_back('{exp_wr: (v.kill_at == 0 && v.rst_at == 0), exp_at: 19});
      if (k == 1) begin
        m_isu  = v.uns;
        m_zero = ZF_EN && (v.divisor == 32'd0);
      end
      if (v.rst_at != 0 && k == v.rst_at) begin
        #1 RESET_D2_R_N = 1'b0;
        m_isu  = 1'b0;
        m_zero = 1'b0;
        #1 check($sformatf("vec%0d_async_rst", idx), k,
                 got_s, model_out(100, 0, 1'b0, MfHiLo_E, DivStart_E, 1'b0, 1'b0));
        break;
      end
      @(negedge CLK);
      check($sformatf("vec%0d", idx), k, got_s,
            model_out(k, v.kill_at, kill_now, MfHiLo_E, DivStart_E, m_isu, m_zero));
      if (HiWrEn) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL vec%0d_sb_spurious k=%0d got=wr exp=none", idx, k);
        end else begin
          e = sb_q.pop_front();
          if (!e.exp_wr || k != e.exp_at) begin
            n_fail++;
            $display("FAIL vec%0d_sb_wr got=k%0d exp=wr%0d@k%0d", idx, k, e.exp_wr, e.exp_at);
          end
        end
      end
      @(posedge CLK);
      #1;
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.exp_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_sb_missing got=no_wr exp=wr@k%0d", idx, e.exp_at);
      end
    end
  endtask

  initial begin
    tbl[0] = '{uns: 1'b1, divisor: 32'd5,          kill_at: 0,  rst_at: 0,  mf_mask: 32'h0008_0020, start_mask: 32'h0};
    tbl[1] = '{uns: 1'b0, divisor: 32'd9,          kill_at: 8,  rst_at: 0,  mf_mask: 32'h0000_0000, start_mask: 32'h0};
    tbl[2] = '{uns: 1'b1, divisor: 32'd0,          kill_at: 0,  rst_at: 0,  mf_mask: 32'h0000_0008, start_mask: 32'h0008_0020};
    tbl[3] = '{uns: 1'b0, divisor: 32'd7,          kill_at: 1,  rst_at: 0,  mf_mask: 32'h0000_0002, start_mask: 32'h0};
    tbl[4] = '{uns: 1'b0, divisor: 32'd3,          kill_at: 19, rst_at: 0,  mf_mask: 32'h0000_1000, start_mask: 32'h0};
    tbl[5] = '{uns: 1'b1, divisor: 32'hFFFF_FFFF,  kill_at: 3,  rst_at: 0,  mf_mask: 32'h0000_0004, start_mask: 32'h0};
    tbl[6] = '{uns: 1'b1, divisor: 32'd0,          kill_at: 0,  rst_at: 10, mf_mask: 32'h0000_0200, start_mask: 32'h0};

    RESET_D2_R_N  = 1'b0;
    DivStart_E    = 1'b0;
    DivUns_E      = 1'b0;
    DivKill       = 1'b0;
    MfHiLo_E      = 1'b0;
    CEI_BOPandV_E = 32'd0;
    #1 check("reset", 0, got_s, model_out(100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_D2_R_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Kill and start together in IDLE: kill wins, nothing captured
    DivStart_E    = 1'b1;
    DivKill       = 1'b1;
    DivUns_E      = ~m_isu;
    CEI_BOPandV_E = 32'd0;
    MfHiLo_E      = 1'b1;
    @(negedge CLK);
    check("idle_kill_start", 0, got_s, model_out(100, 0, 1'b1, 1'b1, 1'b1, m_isu, m_zero));
    @(posedge CLK);
    #1;
    DivStart_E = 1'b0;
    DivKill    = 1'b0;
    MfHiLo_E   = 1'b0;
    @(negedge CLK);
    check("idle_kill_start_after", 1, got_s, model_out(100, 0, 1'b0, 1'b0, 1'b0, m_isu, m_zero));
    @(posedge CLK);
    #1;

    // Asynchronous reset mid-divide, then a fresh divide sequences normally
    run_vec(6, tbl[6]);
    @(negedge CLK);
    check("rst_held", 0, got_s, model_out(100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    RESET_D2_R_N = 1'b1;
    @(posedge CLK);
    #1;
    run_vec(7, tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
